axil_rd_arb: RTL and testbench

Round-robin AXI4-Lite read arbiter that shares one downstream read port between NUM_SRCS requesters, with exactly one transaction in flight. It accepts one AR per source, forwards it from a register, then captures the read response and routes it to the granting source. A response timeout returns SLVERR to the source and later drains the orphaned response. It sits between core-side read masters (fetch, load, debug) and the AXI-Lite interconnect.

---
 rtl/axil_rd_arb.sv | 194 +++++++++++++++++++
 tb/tb_axil_rd_arb.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_rd_arb.sv
// Round-robin AXI4-Lite read arbiter: NUM_SRCS requesters share one downstream
// read port, one transaction in flight, with an R-wait timeout and orphan drain.
module axil_rd_arb #(
  parameter int NUM_SRCS   = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 256
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_SRCS-1:0][ADDR_WIDTH-1:0]  src_axi_araddr,
  input  logic [NUM_SRCS-1:0]                  src_axi_arvalid,
  output logic [NUM_SRCS-1:0]                  src_axi_arready,
  output logic [NUM_SRCS-1:0][DATA_WIDTH-1:0]  src_axi_rdata,
  output logic [NUM_SRCS-1:0][1:0]             src_axi_rresp,
  output logic [NUM_SRCS-1:0]                  src_axi_rvalid,
  input  logic [NUM_SRCS-1:0]                  src_axi_rready,
  output logic [ADDR_WIDTH-1:0]                dst_axi_araddr,
  output logic                                 dst_axi_arvalid,
  input  logic                                 dst_axi_arready,
  input  logic [DATA_WIDTH-1:0]                dst_axi_rdata,
  input  logic [1:0]                           dst_axi_rresp,
  input  logic                                 dst_axi_rvalid,
  output logic                                 dst_axi_rready,
  output logic                                 busy,
  output logic                                 timeout_pulse
);

  localparam int IDX_W = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [IDX_W-1:0] LAST_GNT_RST = IDX_W'(NUM_SRCS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST     = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [1:0]       RESP_SLVERR  = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    AR     = 3'd1,
    R_WAIT = 3'd2,
    R_RESP = 3'd3,
    DRAIN  = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [IDX_W-1:0]       gnt_q, gnt_d;
  logic [IDX_W-1:0]       last_gnt_q, last_gnt_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic [1:0]             rresp_q, rresp_d;
  logic                   drain_q, drain_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic                   arb_found;
  logic [IDX_W-1:0]       arb_idx;

  // Round-robin pick: first requester strictly after the last granted index.
  always_comb begin : rr_pick
    int cand;
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= NUM_SRCS; k++) begin
      cand = (int'(last_gnt_q) + k) % NUM_SRCS;
      if (!arb_found && src_axi_arvalid[cand]) begin
        arb_found = 1'b1;
        arb_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement leaves one unassigned and infers a latch.
    state_d         = state_q;
    addr_d          = addr_q;
    gnt_d           = gnt_q;
    last_gnt_d      = last_gnt_q;
    rdata_d         = rdata_q;
    rresp_d         = rresp_q;
    drain_d         = drain_q;
    cnt_d           = cnt_q;
    src_axi_arready = '0;
    src_axi_rvalid  = '0;
    dst_axi_arvalid = 1'b0;
    dst_axi_rready  = 1'b0;
    timeout_pulse   = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_found) begin
          src_axi_arready[arb_idx] = 1'b1;
          addr_d  = src_axi_araddr[arb_idx];
          gnt_d   = arb_idx;
          state_d = AR;
        end
      end

      AR: begin
        dst_axi_arvalid = 1'b1;
        if (dst_axi_arready) begin
          cnt_d   = '0;
          state_d = R_WAIT;
        end
      end

      R_WAIT: begin
        dst_axi_rready = 1'b1;
        // A real beat beats the timeout when both land in the same cycle.
        if (dst_axi_rvalid) begin
          rdata_d = dst_axi_rdata;
          rresp_d = dst_axi_rresp;
          state_d = R_RESP;
        end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
          rdata_d       = '0;
          rresp_d       = RESP_SLVERR;
          drain_d       = 1'b1;
          timeout_pulse = 1'b1;
          state_d       = R_RESP;
        end else if (TIMEOUT > 0) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      R_RESP: begin
        src_axi_rvalid[gnt_q] = 1'b1;
        if (src_axi_rready[gnt_q]) begin
          last_gnt_d = gnt_q;
          state_d    = drain_q ? DRAIN : IDLE;
        end
      end

      DRAIN: begin
        // The orphaned beat from a timed-out read is swallowed here.
        dst_axi_rready = 1'b1;
        if (dst_axi_rvalid) begin
          drain_d = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Handshake outputs stay quiet while reset is held so nothing is accepted
    // and then silently lost.
    if (!rst_n) begin
      src_axi_arready = '0;
      src_axi_rvalid  = '0;
      dst_axi_arvalid = 1'b0;
      dst_axi_rready  = 1'b0;
      timeout_pulse   = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      gnt_q      <= '0;
      last_gnt_q <= LAST_GNT_RST;
      rdata_q    <= '0;
      rresp_q    <= '0;
      drain_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      drain_q    <= drain_d;
      cnt_q      <= cnt_d;
    end
  end

  assign dst_axi_araddr = addr_q;
  assign busy           = (state_q != IDLE);

  for (genvar i = 0; i < NUM_SRCS; i++) begin : g_bcast
    assign src_axi_rdata[i] = rdata_q;
    assign src_axi_rresp[i] = rresp_q;
  end

  a_rvalid_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(src_axi_rvalid));

  a_ar_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (dst_axi_arvalid && !dst_axi_arready) |=> (dst_axi_arvalid && $stable(dst_axi_araddr)));

endmodule

// File: tb/tb_axil_rd_arb.sv
// Directed bench for axil_rd_arb: the main process drives sources and plays the
// downstream slave; a monitor pops expected responses on every source R handshake.
module tb_axil_rd_arb;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [N-1:0][AW-1:0]   src_axi_araddr;
  logic [N-1:0]           src_axi_arvalid;
  logic [N-1:0]           src_axi_arready;
  logic [N-1:0][DW-1:0]   src_axi_rdata;
  logic [N-1:0][1:0]      src_axi_rresp;
  logic [N-1:0]           src_axi_rvalid;
  logic [N-1:0]           src_axi_rready;
  logic [AW-1:0]          dst_axi_araddr;
  logic                   dst_axi_arvalid;
  logic                   dst_axi_arready;
  logic [DW-1:0]          dst_axi_rdata;
  logic [1:0]             dst_axi_rresp;
  logic                   dst_axi_rvalid;
  logic                   dst_axi_rready;
  logic                   busy;
  logic                   timeout_pulse;

  always #5 clk = ~clk;

  axil_rd_arb #(
    .NUM_SRCS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .src_axi_araddr(src_axi_araddr),
    .src_axi_arvalid(src_axi_arvalid),
    .src_axi_arready(src_axi_arready),
    .src_axi_rdata(src_axi_rdata),
    .src_axi_rresp(src_axi_rresp),
    .src_axi_rvalid(src_axi_rvalid),
    .src_axi_rready(src_axi_rready),
    .dst_axi_araddr(dst_axi_araddr),
    .dst_axi_arvalid(dst_axi_arvalid),
    .dst_axi_arready(dst_axi_arready),
    .dst_axi_rdata(dst_axi_rdata),
    .dst_axi_rresp(dst_axi_rresp),
    .dst_axi_rvalid(dst_axi_rvalid),
    .dst_axi_rready(dst_axi_rready),
    .busy(busy),
    .timeout_pulse(timeout_pulse)
  );

  typedef struct {
    int          src;
    logic [31:0] data;
    logic [1:0]  resp;
    int          issue_cyc;
    int          exp_lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errs   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int src, input logic [31:0] data, input logic [1:0] resp,
                          input int issue_cyc, input int exp_lat);
    exp_t e;
    e.src = src; e.data = data; e.resp = resp; e.issue_cyc = issue_cyc; e.exp_lat = exp_lat;
    sb_q.push_back(e);
  endtask

  // Monitor: samples late in the low phase, after the main process has driven.
  exp_t mon_e;
  int   mon_idx;
  always @(negedge clk) begin
    #3;
    if (rst_n && |(src_axi_rvalid & src_axi_rready)) begin
      mon_idx = -1;
      for (int i = 0; i < N; i++) if (src_axi_rvalid[i]) mon_idx = i;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errs++;
        $display("FAIL unexpected_rresp: src_rvalid=%b with no response expected", src_axi_rvalid);
      end else begin
        mon_e = sb_q.pop_front();
        check("r_src",  64'(mon_idx), 64'(mon_e.src));
        check("r_data", src_axi_rdata[mon_idx], mon_e.data);
        check("r_resp", src_axi_rresp[mon_idx], mon_e.resp);
        if (mon_e.exp_lat >= 0)
          check("r_latency", 64'(cyc - mon_e.issue_cyc), 64'(mon_e.exp_lat));
      end
    end
  end

  task automatic check_quiet(input string tag);
    check({tag, "_arready"}, src_axi_arready, 0);
    check({tag, "_rvalid"},  src_axi_rvalid, 0);
    check({tag, "_rdata"},   src_axi_rdata, 0);
    check({tag, "_rresp"},   src_axi_rresp, 0);
    check({tag, "_arvalid"}, dst_axi_arvalid, 0);
    check({tag, "_araddr"},  dst_axi_araddr, 0);
    check({tag, "_rready"},  dst_axi_rready, 0);
    check({tag, "_busy"},    busy, 0);
    check({tag, "_tpulse"},  timeout_pulse, 0);
  endtask

  // Downstream AR: call at a negedge; returns at the negedge of the first R_WAIT cycle.
  task automatic dst_ar(input logic [31:0] exp_addr, input int ar_wait);
    int n;
    n = 0;
    #1;
    while (!dst_axi_arvalid && n < 20) begin @(negedge clk); #1; n++; end
    check("dst_arvalid", dst_axi_arvalid, 1);
    check("dst_araddr", dst_axi_araddr, exp_addr);
    for (int i = 0; i < ar_wait; i++) begin
      @(negedge clk); #1;
      check("ar_hold_valid", dst_axi_arvalid, 1);
      check("ar_hold_addr", dst_axi_araddr, exp_addr);
    end
    dst_axi_arready = 1'b1;
    @(negedge clk);
    dst_axi_arready = 1'b0;
  endtask

  // Downstream R: beat presented on R_WAIT cycle r_wait+1; returns at the R_RESP negedge.
  task automatic dst_r(input int r_wait, input logic [31:0] data, input logic [1:0] resp);
    repeat (r_wait) @(negedge clk);
    dst_axi_rvalid = 1'b1;
    dst_axi_rdata  = data;
    dst_axi_rresp  = resp;
    #1;
    check("dst_rready", dst_axi_rready, 1);
    check("no_timeout_on_beat", timeout_pulse, 0);
    @(negedge clk);
    dst_axi_rvalid = 1'b0;
    dst_axi_rdata  = '0;
    dst_axi_rresp  = '0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 50) begin @(negedge clk); n++; end
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int n;
    src_axi_araddr  = '0;
    src_axi_arvalid = '0;
    src_axi_rready  = '1;
    dst_axi_arready = 1'b0;
    dst_axi_rdata   = '0;
    dst_axi_rresp   = '0;
    dst_axi_rvalid  = 1'b0;

    repeat (3) @(negedge clk);
    check_quiet("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_quiet("post_reset");

    // Single read, best-case timing: src_rvalid three cycles after arvalid.
    src_axi_araddr[0] = 32'h100;
    src_axi_arvalid   = 2'b01;
    t0 = cyc;
    #1 check("t1_arready", src_axi_arready, 2'b01);
    push_exp(0, 32'hDEADBEEF, 2'b00, t0, 3);
    @(negedge clk);
    src_axi_arvalid = '0;
    dst_ar(32'h100, 0);
    dst_r(0, 32'hDEADBEEF, 2'b00);
    wait_idle("t1");

    // last_gnt is now 0, so with both requesting source 1 must be offered.
    src_axi_arvalid = 2'b11;
    #1 check("lastgnt_probe", src_axi_arready, 2'b10);
    src_axi_arvalid = '0;
    @(negedge clk);

    // Round-robin from reset with both sources requesting continuously.
    pulse_reset();
    src_axi_araddr[0] = 32'h200;
    src_axi_araddr[1] = 32'h300;
    src_axi_arvalid   = 2'b11;
    for (int t = 0; t < 4; t++) begin
      n = 0;
      #1;
      while (src_axi_arready == '0 && n < 20) begin @(negedge clk); #1; n++; end
      check($sformatf("rr%0d_grant", t), src_axi_arready, (t % 2 == 1) ? 2'b10 : 2'b01);
      push_exp(t % 2, 32'h1000 + t, 2'b00, 0, -1);
      @(negedge clk);
      dst_ar((t % 2 == 1) ? 32'h300 : 32'h200, 0);
      dst_r(0, 32'h1000 + t, 2'b00);
    end
    src_axi_arvalid = '0;
    wait_idle("rr");

    // AR backpressure: dst_arready held low for 5 cycles.
    src_axi_araddr[1] = 32'hABC;
    src_axi_arvalid   = 2'b10;
    #1 check("bp_ar_arready", src_axi_arready, 2'b10);
    push_exp(1, 32'h5555AAAA, 2'b01, 0, -1);
    @(negedge clk);
    src_axi_arvalid = '0;
    dst_ar(32'hABC, 5);
    dst_r(0, 32'h5555AAAA, 2'b01);
    wait_idle("bp_ar");

    // R backpressure: src0 not ready for 4 cycles while src1 keeps requesting.
    src_axi_rready    = 2'b10;
    src_axi_araddr[0] = 32'h400;
    src_axi_arvalid   = 2'b01;
    #1 check("bp_r_arready", src_axi_arready, 2'b01);
    push_exp(0, 32'hCAFEF00D, 2'b00, 0, -1);
    @(negedge clk);
    src_axi_arvalid = '0;
    dst_ar(32'h400, 0);
    dst_r(0, 32'hCAFEF00D, 2'b00);
    src_axi_araddr[1] = 32'h500;
    src_axi_arvalid   = 2'b10;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_r_rvalid", src_axi_rvalid, 2'b01);
      check("bp_r_rdata", src_axi_rdata, {2{32'hCAFEF00D}});
      check("bp_r_no_arready", src_axi_arready, 2'b00);
      @(negedge clk);
    end
    src_axi_rready = '1;
    #1 check("bp_r_release_rvalid", src_axi_rvalid, 2'b01);
    push_exp(1, 32'h0BADC0DE, 2'b00, 0, -1);
    @(negedge clk);
    #1 check("bp_r_next_arready", src_axi_arready, 2'b10);
    @(negedge clk);
    src_axi_arvalid = '0;
    dst_ar(32'h500, 0);
    dst_r(0, 32'h0BADC0DE, 2'b00);
    wait_idle("bp_r");

    // Timeout: no beat for 8 R_WAIT cycles, SLVERR returned, late beat drained.
    src_axi_araddr[0] = 32'h600;
    src_axi_arvalid   = 2'b01;
    push_exp(0, 32'h0, 2'b10, 0, -1);
    @(negedge clk);
    src_axi_arvalid = '0;
    dst_ar(32'h600, 0);
    for (int k = 1; k <= TO; k++) begin
      #1 check($sformatf("to_pulse_c%0d", k), timeout_pulse, (k == TO) ? 1'b1 : 1'b0);
      @(negedge clk);
    end
    #1 check("to_rvalid", src_axi_rvalid, 2'b01);
    @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      #1 check("drain_hold", {busy, dst_axi_rready, timeout_pulse, src_axi_rvalid}, 5'b11000);
      @(negedge clk);
    end
    dst_axi_rvalid = 1'b1;
    dst_axi_rdata  = 32'h1234;
    #1 check("drain_absorb_rvalid", src_axi_rvalid, 2'b00);
    @(negedge clk);
    dst_axi_rvalid = 1'b0;
    dst_axi_rdata  = '0;
    #1 check("drain_exit_busy", busy, 0);

    // Timeout boundary: the beat lands on the 8th R_WAIT cycle and wins.
    @(negedge clk);
    src_axi_araddr[0] = 32'h700;
    src_axi_arvalid   = 2'b01;
    push_exp(0, 32'hA5A55A5A, 2'b00, 0, -1);
    @(negedge clk);
    src_axi_arvalid = '0;
    dst_ar(32'h700, 0);
    dst_r(TO - 1, 32'hA5A55A5A, 2'b00);
    #1 check("edge_rvalid", src_axi_rvalid, 2'b01);
    @(negedge clk);
    #1 check("edge_no_drain", busy, 0);

    // Reset while in R_WAIT: outstanding read discarded, source 0 wins next.
    @(negedge clk);
    src_axi_araddr[1] = 32'h800;
    src_axi_arvalid   = 2'b10;
    @(negedge clk);
    src_axi_arvalid = '0;
    dst_ar(32'h800, 0);
    @(negedge clk);
    pulse_reset();
    #1 check_quiet("rst_mid");
    src_axi_araddr[0] = 32'h900;
    src_axi_araddr[1] = 32'hA00;
    src_axi_arvalid   = 2'b11;
    #1 check("rst_next_grant", src_axi_arready, 2'b01);
    push_exp(0, 32'h13579BDF, 2'b00, 0, -1);
    @(negedge clk);
    src_axi_arvalid = '0;
    dst_ar(32'h900, 0);
    dst_r(0, 32'h13579BDF, 2'b00);
    wait_idle("rst_after");

    @(negedge clk);
    check("sb_empty", 64'(sb_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
